detector_saida: RTL and testbench

DETECTOR_SAIDA -- requirements
Module: detector_saida

---
 rtl/detector_saida.sv | 176 +++++++++++++++++
 tb/tb_detector_saida.sv | 238 +++++++++++++++++++++++
 2 files changed

// File: rtl/detector_saida.sv
// ----------------------------------------------------------------------------
// detector_saida
//
// Watches the 1-bit result of an upstream compare stage (Saida). The signal
// arrives from another timing domain, so it is brought into clk through a
// two-flop synchronizer before anything else looks at it.
//
// From the synchronized level (ativo) the block derives:
//   - cont_bordas : saturating count of rising edges of ativo, cleared by limpa
//   - alarme      : raised once ativo has been high for N_CONSEC consecutive
//                   cycles, held until acknowledged with ack
//
// After an acknowledge that arrives while ativo is still high, the block waits
// in BLOQUEADO until ativo has dropped for at least one cycle, so a single
// long high run can raise at most one alarm.
//
// Parameters
//   N_CONSEC  consecutive high cycles of ativo that raise an alarm (2..15)
//   CONT_W    width of the rising-edge counter (2..16)
//
// Ports
//   clk          in   single clock, rising edge
//   rst          in   synchronous, active-high reset
//   Saida        in   raw compare result, asynchronous to clk
//   ack          in   acknowledges a pending alarm (only looked at in ALARME)
//   limpa        in   synchronous clear of cont_bordas (wins over an edge)
//   ativo        out  synchronized level of Saida
//   alarme       out  registered, high exactly while the FSM is in ALARME
//   cont_bordas  out  saturating rising-edge count of ativo
//   estado_dbg   out  current FSM state encoding (debug observation)
//   run_cnt_dbg  out  current run counter value (debug observation)
//
// Handshake: there is no valid/ready pair here. ack is a level sampled on
// each rising edge; one cycle of ack while alarme=1 is enough to leave
// ALARME, and ack is ignored in every other state.
// ----------------------------------------------------------------------------
module detector_saida #(
  parameter int N_CONSEC = 4,
  parameter int CONT_W   = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              Saida,
  input  logic              ack,
  input  logic              limpa,
  output logic              ativo,
  output logic              alarme,
  output logic [CONT_W-1:0] cont_bordas,
  output logic [1:0]        estado_dbg,
  output logic [3:0]        run_cnt_dbg
);

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    CONTANDO  = 2'd1,
    ALARME    = 2'd2,
    BLOQUEADO = 2'd3
  } estado_t;

  localparam logic [3:0]        RUN_MAX  = 4'(N_CONSEC);
  localparam logic [3:0]        RUN_PRE  = 4'(N_CONSEC - 1);
  localparam logic [CONT_W-1:0] CONT_MAX = {CONT_W{1'b1}};

  // Synchronizer and edge detection
  logic s1_q;
  logic ativo_q;
  logic ativo_dly_q;
  logic borda;

  // Counters
  logic [3:0]        run_cnt_q, run_cnt_d;
  logic [CONT_W-1:0] cont_q, cont_d;

  // FSM
  estado_t estado_q, estado_d;
  logic    alarme_q;

  assign borda = ativo_q & ~ativo_dly_q;

  // --------------------------------------------------------------------------
  // Synchronizer chain plus the one-cycle-delayed copy used for edge detect.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q        <= 1'b0;
      ativo_q     <= 1'b0;
      ativo_dly_q <= 1'b0;
    end else begin
      s1_q        <= Saida;
      ativo_q     <= s1_q;
      ativo_dly_q <= ativo_q;
    end
  end

  // --------------------------------------------------------------------------
  // Run counter: counts consecutive high cycles of ativo, parked at N_CONSEC
  // so it never wraps during long runs.
  // --------------------------------------------------------------------------
  always_comb begin
    run_cnt_d = 4'd0;
    if (ativo_q) begin
      if (run_cnt_q >= RUN_MAX) begin
        run_cnt_d = RUN_MAX;
      end else begin
        run_cnt_d = run_cnt_q + 4'd1;
      end
    end
  end

  // --------------------------------------------------------------------------
  // Edge counter: independent of the FSM. limpa has priority over an edge in
  // the same cycle; the count sticks at all-ones instead of wrapping.
  // --------------------------------------------------------------------------
  always_comb begin
    cont_d = cont_q;
    if (limpa) begin
      cont_d = '0;
    end else if (borda && (cont_q != CONT_MAX)) begin
      cont_d = cont_q + 1'b1;
    end
  end

  // --------------------------------------------------------------------------
  // FSM next state. In CONTANDO the compare is against N_CONSEC-1 so that
  // ALARME is entered on the same edge where run_cnt reaches N_CONSEC.
  // --------------------------------------------------------------------------
  always_comb begin
    estado_d = estado_q;
    unique case (estado_q)
      IDLE: begin
        if (ativo_q) estado_d = CONTANDO;
      end
      CONTANDO: begin
        if (!ativo_q) begin
          estado_d = IDLE;
        end else if (run_cnt_q == RUN_PRE) begin
          estado_d = ALARME;
        end
      end
      ALARME: begin
        if (ack) begin
          estado_d = ativo_q ? BLOQUEADO : IDLE;
        end
      end
      BLOQUEADO: begin
        if (!ativo_q) estado_d = IDLE;
      end
      default: estado_d = IDLE;
    endcase
  end

  // --------------------------------------------------------------------------
  // State registers. alarme is its own flop loaded from the next-state decode,
  // so it is a clean registered output that tracks state ALARME exactly.
  // --------------------------------------------------------------------------
  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= 4'd0;
      cont_q    <= '0;
      estado_q  <= IDLE;
      alarme_q  <= 1'b0;
    end else begin
      run_cnt_q <= run_cnt_d;
      cont_q    <= cont_d;
      estado_q  <= estado_d;
      alarme_q  <= (estado_d == ALARME);
    end
  end

  assign ativo       = ativo_q;
  assign alarme      = alarme_q;
  assign cont_bordas = cont_q;
  assign estado_dbg  = estado_q;
  assign run_cnt_dbg = run_cnt_q;

endmodule

// File: tb/tb_detector_saida.sv
// ----------------------------------------------------------------------------
// tb_detector_saida
//
// Directed bench for detector_saida. Two instances share all inputs: dut uses
// the defaults (N_CONSEC=4, CONT_W=8), dut_w2 uses CONT_W=2 to reach counter
// saturation quickly. Inputs change 1 time unit after a rising edge; outputs
// are sampled at the same point, i.e. they show the result of that edge.
// Edge numbering in comments: "eK" is the K-th rising edge after Saida was
// set, matching the latency description of the block.
// ----------------------------------------------------------------------------
module tb_detector_saida;

  localparam int N_CONSEC = 4;

  localparam logic [1:0] ST_IDLE      = 2'd0;
  localparam logic [1:0] ST_CONTANDO  = 2'd1;
  localparam logic [1:0] ST_ALARME    = 2'd2;
  localparam logic [1:0] ST_BLOQUEADO = 2'd3;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst;
  logic saida;
  logic ack;
  logic limpa;

  always #5 clk = ~clk;

  logic       ativo,   ativo_w2;
  logic       alarme,  alarme_w2;
  logic [7:0] cont,    exp_cont;
  logic [1:0] cont_w2;
  logic [1:0] estado,  estado_w2;
  logic [3:0] run_cnt, run_cnt_w2;

  detector_saida #(.N_CONSEC(N_CONSEC), .CONT_W(8)) dut (
    .clk         (clk),
    .rst         (rst),
    .Saida       (saida),
    .ack         (ack),
    .limpa       (limpa),
    .ativo       (ativo),
    .alarme      (alarme),
    .cont_bordas (cont),
    .estado_dbg  (estado),
    .run_cnt_dbg (run_cnt)
  );

  detector_saida #(.N_CONSEC(N_CONSEC), .CONT_W(2)) dut_w2 (
    .clk         (clk),
    .rst         (rst),
    .Saida       (saida),
    .ack         (ack),
    .limpa       (limpa),
    .ativo       (ativo_w2),
    .alarme      (alarme_w2),
    .cont_bordas (cont_w2),
    .estado_dbg  (estado_w2),
    .run_cnt_dbg (run_cnt_w2)
  );

  // ---------------- scoreboard ----------------
  int n_checks = 0;
  int n_fail   = 0;
  logic [7:0] exp_q[$];

  task automatic check(input string tag, input int unsigned obs, input int unsigned exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic steps(input int n);
    for (int i = 0; i < n; i++) step();
  endtask

  task automatic do_reset();
    rst   = 1'b1;
    saida = 1'b0;
    ack   = 1'b0;
    limpa = 1'b0;
    steps(2);
    rst = 1'b0;
  endtask

  // Isolated Saida pulse: 2 cycles high, 3 low. The edge counter has already
  // updated by the time the task returns.
  task automatic pulse();
    saida = 1'b1;
    steps(2);
    saida = 1'b0;
    steps(3);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    // Reset state: outputs all 0 while rst is held
    rst = 1'b1; saida = 1'b1; ack = 1'b1; limpa = 1'b0;
    steps(3);
    check("rst_ativo",   ativo,   0);
    check("rst_alarme",  alarme,  0);
    check("rst_cont",    cont,    0);
    check("rst_estado",  estado,  ST_IDLE);
    check("rst_cont_w2", cont_w2, 0);

    // Basic alarm: Saida held high from before e1
    do_reset();
    saida = 1'b1;
    step();                                   // e1
    check("basic_ativo_e1", ativo, 0);
    step();                                   // e2
    check("basic_ativo_e2", ativo, 1);
    check("basic_cont_e2",  cont,  0);
    step();                                   // e3
    check("basic_cont_e3",  cont,    1);
    check("basic_run_e3",   run_cnt, 1);
    check("basic_st_e3",    estado,  ST_CONTANDO);
    steps(2);                                 // e5
    check("basic_alarme_e5", alarme, 0);
    step();                                   // e6
    check("basic_alarme_e6", alarme, 1);
    check("basic_run_e6",    run_cnt, N_CONSEC);
    steps(4);                                 // e10
    check("basic_alarme_e10", alarme, 1);
    check("basic_st_e10",     estado, ST_ALARME);
    check("basic_run_sat",    run_cnt, N_CONSEC);

    // Acknowledge while still high -> BLOQUEADO, no re-alarm
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_alarme",  alarme, 0);
    check("ack_estado",  estado, ST_BLOQUEADO);
    for (int i = 0; i < 5; i++) begin
      step();
      check("blk_alarme", alarme, 0);
    end
    check("blk_estado", estado, ST_BLOQUEADO);

    // Saida low one cycle, then high again: new alarm N_CONSEC+2 edges later
    saida = 1'b0;
    step();                                   // a1
    saida = 1'b1;
    steps(5);                                 // a6
    check("realarm_a6", alarme, 0);
    step();                                   // a7
    check("realarm_a7", alarme, 1);
    check("realarm_cont",    cont,    2);
    check("realarm_cont_w2", cont_w2, 2);

    // Drop Saida, then ack with ativo low -> IDLE
    saida = 1'b0;
    steps(3);
    check("hold_alarme_ack0", alarme, 1);
    ack = 1'b1;
    step();
    ack = 1'b0;
    check("ack_low_alarme", alarme, 0);
    check("ack_low_estado", estado, ST_IDLE);

    // Ack in IDLE is ignored
    ack = 1'b1;
    steps(2);
    ack = 1'b0;
    check("ack_idle_estado", estado, ST_IDLE);

    // Short run: 3 cycles high never alarms
    do_reset();
    saida = 1'b1;
    steps(3);
    saida = 1'b0;
    for (int i = 0; i < 8; i++) begin
      step();
      check("short_alarme", alarme, 0);
    end
    check("short_cont", cont,    1);
    check("short_run",  run_cnt, 0);
    check("short_st",   estado,  ST_IDLE);

    // Saturation with CONT_W=2; the 8-bit instance keeps counting
    do_reset();
    for (int i = 1; i <= 5; i++) begin
      pulse();
      exp_q.push_back(8'(i));
      check("sat_cont_w2", cont_w2, (i > 3) ? 3 : i);
    end
    while (exp_q.size() > 1) void'(exp_q.pop_front());
    exp_cont = exp_q.pop_front();
    check("sat_cont_w8", cont, exp_cont);
    check("sat_no_alarm", alarme, 0);

    // limpa on the same cycle as a borda: clear wins
    saida = 1'b1;
    steps(2);                                 // ativo=1 at q2, borda now
    limpa = 1'b1;
    step();                                   // q3
    limpa = 1'b0;
    check("limpa_cont",    cont,    0);
    check("limpa_cont_w2", cont_w2, 0);
    saida = 1'b0;
    steps(3);
    check("limpa_hold", cont, 0);

    // Reset mid-operation: ALARME with cont=7
    do_reset();
    for (int i = 0; i < 6; i++) pulse();
    saida = 1'b1;
    steps(6);
    check("mid_alarme", alarme, 1);
    check("mid_cont",   cont,   7);
    rst = 1'b1;
    step();
    rst = 1'b0;
    check("mid_rst_alarme", alarme, 0);
    check("mid_rst_cont",   cont,   0);
    check("mid_rst_ativo",  ativo,  0);
    check("mid_rst_estado", estado, ST_IDLE);
    check("mid_rst_w2",     cont_w2, 0);
    steps(5);                                 // r5
    check("post_rst_r5", alarme, 0);
    step();                                   // r6
    check("post_rst_r6", alarme, 1);
    check("post_rst_cont", cont, 1);

    // ---------------- report ----------------
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
